// File: rtl/cpu_pkg.sv
// Shared opcode, state and ALU-select encodings plus the control-bundle types
// used by the control unit and its opcode decoder.
package cpu_pkg;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 3;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [STATE_W-1:0] ST_T0   = 4'd0;
  localparam logic [STATE_W-1:0] ST_T1   = 4'd1;
  localparam logic [STATE_W-1:0] ST_T2   = 4'd2;
  localparam logic [STATE_W-1:0] ST_T3   = 4'd3;
  localparam logic [STATE_W-1:0] ST_T4   = 4'd4;
  localparam logic [STATE_W-1:0] ST_T5   = 4'd5;
  localparam logic [STATE_W-1:0] ST_T6   = 4'd6;
  localparam logic [STATE_W-1:0] ST_T7   = 4'd7;
  localparam logic [STATE_W-1:0] ST_HALT = 4'd8;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic write;
    logic gra;
    logic grb;
    logic grc;
    logic ba_out;
    logic r_in;
    logic r_out;
    logic rc_out;
    logic y_in;
    logic zlow_in;
    logic zlow_out;
  } ctrl_t;

  typedef struct packed {
    logic ld;
    logic ldi;
    logic st;
    logic alu_rr;
    logic alu_imm;
    logic nop;
    logic halt;
  } iclass_t;

endpackage

// File: rtl/opcode_decode.sv
// Maps the 5-bit opcode to an instruction class and the ALU operation used in T4.
// Any opcode not otherwise recognised is classed as a nop.
module opcode_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]  op_i,
  output iclass_t          iclass_o,
  output logic [ALU_W-1:0] alu_sel_o
);

  always_comb begin
    iclass_o  = '0;
    alu_sel_o = ALU_ADD;
    case (op_i)
      OP_LD:   iclass_o.ld  = 1'b1;
      OP_LDI:  iclass_o.ldi = 1'b1;
      OP_ST:   iclass_o.st  = 1'b1;
      OP_ADD:  iclass_o.alu_rr = 1'b1;
      OP_SUB:  begin iclass_o.alu_rr = 1'b1; alu_sel_o = ALU_SUB; end
      OP_AND:  begin iclass_o.alu_rr = 1'b1; alu_sel_o = ALU_AND; end
      OP_OR:   begin iclass_o.alu_rr = 1'b1; alu_sel_o = ALU_OR;  end
      OP_ADDI: iclass_o.alu_imm = 1'b1;
      OP_ANDI: begin iclass_o.alu_imm = 1'b1; alu_sel_o = ALU_AND; end
      OP_ORI:  begin iclass_o.alu_imm = 1'b1; alu_sel_o = ALU_OR;  end
      OP_HALT: iclass_o.halt = 1'b1;
      default: iclass_o.nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM for the multi-cycle CPU: fetch T0-T2, opcode-driven execute
// T3-T7, and a HALT state left only by reset.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        BAout,
  output logic        Rin,
  output logic        Rout,
  output logic        RCout,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZLowOut,
  output logic [2:0]  aluSel
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               started_q;
  logic [OP_W-1:0]    op;
  logic               unused_ir;
  iclass_t            iclass;
  logic [ALU_W-1:0]   dec_alu_sel;
  ctrl_t              ctrl_c;
  logic [ALU_W-1:0]   alu_sel_c;
  logic               instr_end;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  opcode_decode u_decode (
    .op_i      (op),
    .iclass_o  (iclass),
    .alu_sel_o (dec_alu_sel)
  );

  // started_q holds outputs quiet from reset until the first clock after clear rises
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_T0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_c    = '0;
    alu_sel_c = ALU_ADD;
    instr_end = 1'b0;
    case (state_q)
      ST_T0: begin
        ctrl_c.pc_out = 1'b1; ctrl_c.mar_in = 1'b1; ctrl_c.inc_pc = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        ctrl_c.read = 1'b1; ctrl_c.mdr_in = 1'b1;
        state_d = ST_T2;
      end
      ST_T2: begin
        ctrl_c.mdr_out = 1'b1; ctrl_c.ir_in = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        if (iclass.halt) begin
          state_d = ST_HALT;
        end else if (iclass.nop) begin
          instr_end = 1'b1;
        end else begin
          ctrl_c.grb = 1'b1; ctrl_c.y_in = 1'b1;
          if (iclass.alu_rr || iclass.alu_imm) ctrl_c.r_out  = 1'b1;
          else                                 ctrl_c.ba_out = 1'b1;
          state_d = ST_T4;
        end
      end
      ST_T4: begin
        ctrl_c.zlow_in = 1'b1;
        alu_sel_c      = dec_alu_sel;
        if (iclass.alu_rr) begin
          ctrl_c.grc = 1'b1; ctrl_c.r_out = 1'b1;
        end else begin
          ctrl_c.rc_out = 1'b1;
        end
        state_d = ST_T5;
      end
      ST_T5: begin
        ctrl_c.zlow_out = 1'b1;
        if (iclass.ld || iclass.st) begin
          ctrl_c.mar_in = 1'b1;
          state_d = ST_T6;
        end else begin
          ctrl_c.gra = 1'b1; ctrl_c.r_in = 1'b1;
          instr_end = 1'b1;
        end
      end
      ST_T6: begin
        ctrl_c.mdr_in = 1'b1;
        if (iclass.st) begin
          ctrl_c.gra = 1'b1; ctrl_c.r_out = 1'b1;
        end else begin
          ctrl_c.read = 1'b1;
        end
        state_d = ST_T7;
      end
      ST_T7: begin
        if (iclass.st) begin
          ctrl_c.write = 1'b1;
        end else begin
          ctrl_c.mdr_out = 1'b1; ctrl_c.gra = 1'b1; ctrl_c.r_in = 1'b1;
        end
        instr_end = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase

    // Stop is honoured only on the last state of an instruction
    if (instr_end) state_d = Stop ? ST_HALT : ST_T0;

    if (!started_q) begin
      state_d   = ST_T0;
      ctrl_c    = '0;
      alu_sel_c = ALU_ADD;
    end
  end

  assign Run     = (state_q != ST_HALT);
  assign PCout   = ctrl_c.pc_out;
  assign MARin   = ctrl_c.mar_in;
  assign IncPC   = ctrl_c.inc_pc;
  assign Read    = ctrl_c.read;
  assign MDRin   = ctrl_c.mdr_in;
  assign MDRout  = ctrl_c.mdr_out;
  assign IRin    = ctrl_c.ir_in;
  assign Write   = ctrl_c.write;
  assign Gra     = ctrl_c.gra;
  assign Grb     = ctrl_c.grb;
  assign Grc     = ctrl_c.grc;
  assign BAout   = ctrl_c.ba_out;
  assign Rin     = ctrl_c.r_in;
  assign Rout    = ctrl_c.r_out;
  assign RCout   = ctrl_c.rc_out;
  assign Yin     = ctrl_c.y_in;
  assign ZLowIn  = ctrl_c.zlow_in;
  assign ZLowOut = ctrl_c.zlow_out;
  assign aluSel  = alu_sel_c;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each cycle the stimulus pushes the expected
// output vector and a negedge monitor pops and compares it.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] IR    = 32'h0;
  logic        Stop  = 1'b0;
  logic        Run, PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Write;
  logic        Gra, Grb, Grc, BAout, Rin, Rout, RCout, Yin, ZLowIn, ZLowOut;
  logic [2:0]  aluSel;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .Stop(Stop), .Run(Run),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Write(Write), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .BAout(BAout), .Rin(Rin), .Rout(Rout), .RCout(RCout),
    .Yin(Yin), .ZLowIn(ZLowIn), .ZLowOut(ZLowOut), .aluSel(aluSel)
  );

  always #5 clock = ~clock;

  localparam logic [21:0] RUN    = 22'(1) << 21;
  localparam logic [21:0] A_SUB  = 22'(1) << 18;
  localparam logic [21:0] A_AND  = 22'(2) << 18;
  localparam logic [21:0] A_OR   = 22'(3) << 18;
  localparam logic [21:0] PCOUT  = 22'(1) << 17;
  localparam logic [21:0] MARIN  = 22'(1) << 16;
  localparam logic [21:0] INCPC  = 22'(1) << 15;
  localparam logic [21:0] READ   = 22'(1) << 14;
  localparam logic [21:0] MDRIN  = 22'(1) << 13;
  localparam logic [21:0] MDROUT = 22'(1) << 12;
  localparam logic [21:0] IRIN   = 22'(1) << 11;
  localparam logic [21:0] WRITE  = 22'(1) << 10;
  localparam logic [21:0] GRA    = 22'(1) << 9;
  localparam logic [21:0] GRB    = 22'(1) << 8;
  localparam logic [21:0] GRC    = 22'(1) << 7;
  localparam logic [21:0] BAOUT  = 22'(1) << 6;
  localparam logic [21:0] RIN    = 22'(1) << 5;
  localparam logic [21:0] ROUT   = 22'(1) << 4;
  localparam logic [21:0] RCOUT  = 22'(1) << 3;
  localparam logic [21:0] YIN    = 22'(1) << 2;
  localparam logic [21:0] ZLI    = 22'(1) << 1;
  localparam logic [21:0] ZLO    = 22'(1) << 0;

  logic [21:0] act;
  assign act = {Run, aluSel, PCout, MARin, IncPC, Read, MDRin, MDRout, IRin,
                Write, Gra, Grb, Grc, BAout, Rin, Rout, RCout, Yin, ZLowIn, ZLowOut};

  logic [21:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  task automatic step(input logic [21:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ir, input string n);
    IR = ir;
    step(RUN | PCOUT | MARIN | INCPC, {n, " T0"});
    step(RUN | READ | MDRIN,          {n, " T1"});
    step(RUN | MDROUT | IRIN,         {n, " T2"});
  endtask

  task automatic mem_front(input string n);
    step(RUN | GRB | BAOUT | YIN, {n, " T3"});
    step(RUN | RCOUT | ZLI,       {n, " T4"});
  endtask

  task automatic alu_instr(input logic [31:0] ir, input logic [21:0] e3,
                           input logic [21:0] e4, input string n);
    fetch(ir, n);
    step(e3, {n, " T3"});
    step(e4, {n, " T4"});
    step(RUN | ZLO | GRA | RIN, {n, " T5"});
  endtask

  task automatic do_reset(input string n);
    clear = 1'b0;
    Stop  = 1'b0;
    step(RUN, {n, " held"});
    step(RUN, {n, " held"});
    clear = 1'b1;
    step(RUN, {n, " released"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock);
    #1;
    do_reset("reset");

    // ld r1,0x55(r0)
    fetch(32'h0080_0055, "ld");
    mem_front("ld");
    step(RUN | ZLO | MARIN,        "ld T5");
    step(RUN | READ | MDRIN,       "ld T6");
    step(RUN | MDROUT | GRA | RIN, "ld T7");

    alu_instr(32'h1989_0000, RUN | GRB | ROUT | YIN, RUN | GRC | ROUT | ZLI, "add");
    alu_instr(32'h2000_0000, RUN | GRB | ROUT | YIN, RUN | GRC | ROUT | ZLI | A_SUB, "sub");
    alu_instr(32'h2800_0000, RUN | GRB | ROUT | YIN, RUN | GRC | ROUT | ZLI | A_AND, "and");
    alu_instr(32'h7000_0000, RUN | GRB | ROUT | YIN, RUN | RCOUT | ZLI | A_OR, "ori");
    alu_instr(32'h6800_0000, RUN | GRB | ROUT | YIN, RUN | RCOUT | ZLI | A_AND, "andi");

    // st
    fetch(32'h1080_0010, "st");
    mem_front("st");
    step(RUN | ZLO | MARIN,        "st T5");
    step(RUN | GRA | ROUT | MDRIN, "st T6");
    step(RUN | WRITE,              "st T7");

    fetch(32'hD000_0000, "nop");
    step(RUN, "nop T3");
    fetch(32'hF800_0000, "undef");
    step(RUN, "undef T3");

    // Stop outside instruction end is ignored
    Stop = 1'b1;
    fetch(32'h0800_0000, "ldi");
    step(RUN | GRB | BAOUT | YIN, "ldi T3");
    step(RUN | RCOUT | ZLI, "ldi T4 stop");
    Stop = 1'b0;
    step(RUN | ZLO | GRA | RIN, "ldi T5");

    // async reset during T6 of st must suppress the T7 Write
    fetch(32'h1080_0010, "st rst");
    mem_front("st rst");
    step(RUN | ZLO | MARIN, "st rst T5");
    exp_q.push_back(RUN);
    name_q.push_back("st rst async");
    #2 clear = 1'b0;
    @(posedge clock);
    #1;
    step(RUN, "st rst held");
    step(RUN, "st rst held");
    clear = 1'b1;
    step(RUN, "st rst released");

    // Stop at ldi end halts
    fetch(32'h0800_0000, "ldi halt");
    mem_front("ldi halt");
    Stop = 1'b1;
    step(RUN | ZLO | GRA | RIN, "ldi halt T5");
    Stop = 1'b0;
    repeat (3) step(22'h0, "stopped");

    do_reset("reset2");
    fetch(32'hD800_0000, "halt");
    step(RUN, "halt T3");
    repeat (20) step(22'h0, "halted");

    // halt op with Stop at T3
    do_reset("reset3");
    fetch(32'hD800_0000, "halt+stop");
    Stop = 1'b1;
    step(RUN, "halt+stop T3");
    repeat (2) step(22'h0, "halt+stop halted");

    do_reset("reset4");
    fetch(32'h0000_0000, "final");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
